// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: data/index widths, ALU op codes
// and the operand-forwarding source select.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_OR  = 3'b010,
        ALU_XOR = 3'b011,
        ALU_AND = 3'b100,
        ALU_SRA = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EXM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/ex_issue_reg_fwd_mux.sv
// Per-source operand bypass: picks the youngest matching producer (EX/MEM over
// MEM/WB) for a registered source index. With EN=0 it passes the register through.
module fwd_mux
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN,
    parameter int REGW = alu_pkg::REGW,
    parameter bit EN   = 1'b1
) (
    input  logic [REGW-1:0] rs_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [REGW-1:0] exm_rd_i,
    input  logic            exm_we_i,
    input  logic [XLEN-1:0] exm_res_i,
    input  logic [REGW-1:0] wb_rd_i,
    input  logic            wb_we_i,
    input  logic [XLEN-1:0] wb_res_i,
    output logic [XLEN-1:0] data_o,
    output fwd_sel_t        sel_o
);

    // x0 is hardwired to zero, so a producer "writing" x0 must never bypass.
    always_comb begin
        sel_o  = FWD_NONE;
        data_o = data_i;
        if (EN && (rs_i != '0)) begin
            if (exm_we_i && (exm_rd_i == rs_i)) begin
                sel_o  = FWD_EXM;
                data_o = exm_res_i;
            end else if (wb_we_i && (wb_rd_i == rs_i)) begin
                sel_o  = FWD_WB;
                data_o = wb_res_i;
            end
        end
    end

endmodule

// File: rtl/ex_issue_reg.sv
// ID/EX stage register feeding the ALU, with RAW forwarding and load-use stall.
// Build option: define EX_FORWARD_EN for bypassing; otherwise decode stalls on any RAW match.
module ex_issue_reg
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN,
    parameter int REGW = alu_pkg::REGW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic [2:0]      id_alu_op,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    input  logic [REGW-1:0] exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [REGW-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result
);

`ifdef EX_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic            valid_q, valid_d;
    logic [REGW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            use_imm_q, use_imm_d;
    alu_op_t         alu_op_q, alu_op_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q, mem_read_d;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    fwd_sel_t        rs1_sel, rs2_sel;
    logic            hazard, capture;

    fwd_mux #(.XLEN(XLEN), .REGW(REGW), .EN(FWD_EN)) u_fwd_rs1 (
        .rs_i(rs1_q), .data_i(rs1_data_q),
        .exm_rd_i(exm_rd), .exm_we_i(exm_reg_write), .exm_res_i(exm_result),
        .wb_rd_i(wb_rd), .wb_we_i(wb_reg_write), .wb_res_i(wb_result),
        .data_o(rs1_fwd), .sel_o(rs1_sel)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW), .EN(FWD_EN)) u_fwd_rs2 (
        .rs_i(rs2_q), .data_i(rs2_data_q),
        .exm_rd_i(exm_rd), .exm_we_i(exm_reg_write), .exm_res_i(exm_result),
        .wb_rd_i(wb_rd), .wb_we_i(wb_reg_write), .wb_res_i(wb_result),
        .data_o(rs2_fwd), .sel_o(rs2_sel)
    );

`ifdef EX_FORWARD_EN
    // Only a load in this stage cannot be bypassed in time; compared even for imm forms.
    assign hazard = valid_q && mem_read_q && (rd_q != '0) &&
                    ((rd_q == id_rs1) || (rd_q == id_rs2));
`else
    logic rs1_busy, rs2_busy;
    always_comb begin
        rs1_busy = (id_rs1 != '0) &&
                   ((valid_q && reg_write_q && (rd_q == id_rs1)) ||
                    (exm_reg_write && (exm_rd == id_rs1)) ||
                    (wb_reg_write && (wb_rd == id_rs1)));
        rs2_busy = (id_rs2 != '0) &&
                   ((valid_q && reg_write_q && (rd_q == id_rs2)) ||
                    (exm_reg_write && (exm_rd == id_rs2)) ||
                    (wb_reg_write && (wb_rd == id_rs2)));
    end
    assign hazard = rs1_busy || rs2_busy;
`endif

    // Handshake: a transfer happens on a rising edge when valid && ready are both high.
    assign id_ready = (!valid_q || ex_ready) && !hazard;
    assign capture  = id_valid && id_ready && !flush;

    always_comb begin
        valid_d     = valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d     = 1'b1;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            alu_op_d    = alu_op_t'(id_alu_op);
            rd_d        = id_rd;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
        end else if (valid_q && ex_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: latch bypassed values so producers retiring now are not lost.
            if (rs1_sel != FWD_NONE) rs1_data_d = rs1_fwd;
            if (rs2_sel != FWD_NONE) rs2_data_d = rs2_fwd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            alu_op_q    <= ALU_ADD;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    assign ex_valid     = valid_q;
    assign alu_a        = rs1_fwd;
    assign alu_b        = use_imm_q ? imm_q : rs2_fwd;
    assign alu_op       = alu_op_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;

endmodule

// File: tb/tb_ex_issue_reg.sv
// Self-checking bench for ex_issue_reg: directed hazard/forward/flush/reset cases,
// then randomized traffic against an instruction-level model and scoreboard.
module tb_ex_issue_reg;
    import alu_pkg::*;

    localparam int EW = 2 * XLEN + 3 + REGW + 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid, id_ready;
    logic [REGW-1:0] id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic            id_use_imm, id_reg_write, id_mem_read;
    logic [2:0]      id_alu_op;
    logic            flush, ex_ready, ex_valid;
    logic [XLEN-1:0] alu_a, alu_b;
    logic [2:0]      alu_op;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write, ex_mem_read;
    logic [REGW-1:0] exm_rd, wb_rd;
    logic            exm_reg_write, wb_reg_write;
    logic [XLEN-1:0] exm_result, wb_result;

    ex_issue_reg dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_q[$];
    bit            sb_on = 1'b0;

    // Instruction currently expected to sit in the stage.
    bit            occ_valid = 1'b0;
    logic [REGW-1:0] occ_rd  = '0;
    bit            occ_rw    = 1'b0;
    bit            occ_mr    = 1'b0;

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_data = '0; id_rs2_data = '0;
        id_imm = '0; id_use_imm = 1'b0; id_alu_op = 3'b000; id_rd = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        exm_rd = '0; exm_reg_write = 1'b0; exm_result = '0;
        wb_rd = '0; wb_reg_write = 1'b0; wb_result = '0;
    endtask

    task automatic present(input logic [REGW-1:0] rs1, input logic [XLEN-1:0] d1,
                           input logic [REGW-1:0] rs2, input logic [XLEN-1:0] d2,
                           input logic [XLEN-1:0] imm, input logic use_imm, input logic [2:0] op,
                           input logic [REGW-1:0] rd, input logic rw, input logic mr);
        id_valid = 1'b1; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
        id_imm = imm; id_use_imm = use_imm; id_alu_op = op; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ex_valid"}, XLEN'(ex_valid), 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_op"}, XLEN'(alu_op), 0);
        check({tag, "_ex_rd"}, XLEN'(ex_rd), 0);
        check({tag, "_ex_reg_write"}, XLEN'(ex_reg_write), 0);
        check({tag, "_ex_mem_read"}, XLEN'(ex_mem_read), 0);
        check({tag, "_id_ready"}, XLEN'(id_ready), 1);
    endtask

    // Stage-level hazard rules, evaluated on the model's view of the stage.
    function automatic bit src_blocked(input logic [REGW-1:0] rs);
`ifdef EX_FORWARD_EN
        return occ_valid && occ_mr && (occ_rd != 0) && (occ_rd == rs);
`else
        if (rs == 0) return 1'b0;
        return (occ_valid && occ_rw && (occ_rd == rs)) ||
               (exm_reg_write && (exm_rd == rs)) || (wb_reg_write && (wb_rd == rs));
`endif
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        #2;
        if (sb_on && rst_n && ex_valid && ex_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got output a=0x%0h with no expected entry", alu_a);
            end else begin
                logic [EW-1:0] exp_v, got_v;
                exp_v = exp_q.pop_front();
                got_v = {alu_a, alu_b, alu_op, ex_rd, ex_reg_write, ex_mem_read};
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL sb_output: got 0x%0h expected 0x%0h", got_v, exp_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_id_ready", XLEN'(id_ready), 1);

        // ADDI x5 = x1(5) + 7
        present(5'd1, 32'd5, 5'd0, 32'd0, 32'd7, 1'b1, ALU_ADD, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        check("addi_ex_valid", XLEN'(ex_valid), 1);
        check("addi_alu_a", alu_a, 5);
        check("addi_alu_b", alu_b, 7);
        check("addi_alu_op", XLEN'(alu_op), 0);
        check("addi_ex_rd", XLEN'(ex_rd), 5);
        id_valid = 1'b0;
        @(negedge clk);
        check("addi_drained", XLEN'(ex_valid), 0);

        // Load into x4 followed by a consumer of x4 on rs2
        present(5'd0, 32'd0, 5'd0, 32'd0, 32'd16, 1'b1, ALU_ADD, 5'd4, 1'b1, 1'b1);
        @(negedge clk);
        check("ld_ex_mem_read", XLEN'(ex_mem_read), 1);
        present(5'd6, 32'h100, 5'd4, 32'h33, 32'd0, 1'b0, ALU_SUB, 5'd8, 1'b1, 1'b0);
        #1 check("lu_id_ready_stall", XLEN'(id_ready), 0);
        @(negedge clk);
        check("lu_bubble", XLEN'(ex_valid), 0);
        check("lu_id_ready_after", XLEN'(id_ready), 1);
        @(negedge clk);
        check("lu_capture_valid", XLEN'(ex_valid), 1);
        check("lu_capture_alu_b", alu_b, 32'h33);
        check("lu_capture_op", XLEN'(alu_op), 1);
        id_valid = 1'b0;
        @(negedge clk);

        // Flush kills the held instruction and blocks the decoded one
        present(5'd1, 32'h1, 5'd2, 32'h2, 32'd0, 1'b0, ALU_OR, 5'd6, 1'b1, 1'b0);
        @(negedge clk);
        check("fl_pre_valid", XLEN'(ex_valid), 1);
        present(5'd1, 32'h9, 5'd2, 32'h9, 32'd0, 1'b0, ALU_XOR, 5'd9, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; id_valid = 1'b0;
        check("fl_valid", XLEN'(ex_valid), 0);
        check("fl_not_captured_rd", XLEN'(ex_rd), 6);
        @(negedge clk);
        check("fl_still_empty", XLEN'(ex_valid), 0);

        // Held instruction reading x3 while producers of x3 come and go
`ifdef EX_FORWARD_EN
        present(5'd3, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, ALU_ADD, 5'd7, 1'b1, 1'b0);
        @(negedge clk);
        id_valid = 1'b0; ex_ready = 1'b0;
        exm_rd = 5'd3; exm_reg_write = 1'b1; exm_result = 32'hAA;
        wb_rd = 5'd3; wb_reg_write = 1'b1; wb_result = 32'hBB;
        #1 check("fwd_exm_wins", alu_a, 32'hAA);
        exm_rd = 5'd0;
        #1 check("fwd_wb", alu_a, 32'hBB);
        exm_rd = 5'd3;
        @(negedge clk);
        exm_reg_write = 1'b0; wb_result = 32'hAA;
        #1 check("fwd_hold1", alu_a, 32'hAA);
        @(negedge clk);
        wb_reg_write = 1'b0;
        #1 check("fwd_hold2", alu_a, 32'hAA);
        ex_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        present(5'd2, 32'h44, 5'd0, 32'h0, 32'h0, 1'b0, ALU_AND, 5'd1, 1'b1, 1'b0);
        exm_rd = 5'd2; exm_reg_write = 1'b1; exm_result = 32'h55;
        #1 check("fwd_no_stall", XLEN'(id_ready), 1);
        @(negedge clk);
        check("fwd_cap_alu_a", alu_a, 32'h55);
        idle_inputs();
        @(negedge clk);
`else
        present(5'd3, 32'h11, 5'd0, 32'h0, 32'h0, 1'b0, ALU_ADD, 5'd7, 1'b1, 1'b0);
        @(negedge clk);
        id_valid = 1'b0; ex_ready = 1'b0;
        exm_rd = 5'd3; exm_reg_write = 1'b1; exm_result = 32'hAA;
        #1 check("nofwd_alu_a", alu_a, 32'h11);
        check("nofwd_busy_ready", XLEN'(id_ready), 0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        // rs1=x2 stalls until neither EX/MEM nor MEM/WB writes x2
        present(5'd2, 32'h44, 5'd0, 32'h0, 32'h0, 1'b0, ALU_AND, 5'd1, 1'b1, 1'b0);
        exm_rd = 5'd2; exm_reg_write = 1'b1;
        #1 check("raw_exm_stall", XLEN'(id_ready), 0);
        @(negedge clk);
        check("raw_exm_no_cap", XLEN'(ex_valid), 0);
        exm_reg_write = 1'b0; wb_rd = 5'd2; wb_reg_write = 1'b1;
        #1 check("raw_wb_stall", XLEN'(id_ready), 0);
        @(negedge clk);
        check("raw_wb_no_cap", XLEN'(ex_valid), 0);
        wb_reg_write = 1'b0;
        #1 check("raw_clear", XLEN'(id_ready), 1);
        @(negedge clk);
        check("raw_cap_valid", XLEN'(ex_valid), 1);
        check("raw_cap_alu_a", alu_a, 32'h44);
        idle_inputs();
        @(negedge clk);
`endif

        // Asynchronous reset while an instruction is held
        present(5'd1, 32'h77, 5'd2, 32'h88, 32'h0, 1'b0, ALU_SLL, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        idle_inputs(); ex_ready = 1'b0;
        check("mid_pre_valid", XLEN'(ex_valid), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1; ex_ready = 1'b1;

        // Randomized traffic against the instruction-level model
        occ_valid = 1'b0;
        exp_q.delete();
        sb_on = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit quiet, exp_ready, cap;
            @(negedge clk);
            quiet = (cyc >= 2995);
            id_valid     = !quiet && ($urandom_range(0, 3) != 0);
            id_rs1       = REGW'($urandom_range(0, 7));
            id_rs2       = REGW'($urandom_range(0, 7));
            id_rs1_data  = $urandom();
            id_rs2_data  = $urandom();
            id_imm       = $urandom();
            id_use_imm   = $urandom_range(0, 1) == 1;
            id_alu_op    = 3'($urandom_range(0, 7));
            id_rd        = REGW'($urandom_range(0, 7));
            id_reg_write = $urandom_range(0, 3) != 0;
            id_mem_read  = $urandom_range(0, 3) == 0;
            ex_ready     = quiet || ($urandom_range(0, 3) != 0);
            flush        = !quiet && ($urandom_range(0, 15) == 0);
            if (flush) ex_ready = 1'b0;
            exm_rd       = REGW'($urandom_range(0, 7));
            wb_rd        = REGW'($urandom_range(0, 7));
            exm_result   = $urandom();
            wb_result    = $urandom();
`ifdef EX_FORWARD_EN
            exm_reg_write = 1'b0;
            wb_reg_write  = 1'b0;
`else
            exm_reg_write = !quiet && ($urandom_range(0, 4) == 0);
            wb_reg_write  = !quiet && ($urandom_range(0, 4) == 0);
`endif
            #1;
            exp_ready = (!occ_valid || ex_ready) && !src_blocked(id_rs1) && !src_blocked(id_rs2);
            check("rnd_id_ready", XLEN'(id_ready), XLEN'(exp_ready));
            check("rnd_ex_valid", XLEN'(ex_valid), XLEN'(occ_valid));
            cap = id_valid && exp_ready && !flush;
            if (flush) begin
                if (occ_valid && exp_q.size() != 0) void'(exp_q.pop_back());
                occ_valid = 1'b0;
            end else if (cap) begin
                exp_q.push_back({id_rs1_data, (id_use_imm ? id_imm : id_rs2_data), id_alu_op,
                                 id_rd, id_reg_write, id_mem_read});
                occ_valid = 1'b1; occ_rd = id_rd; occ_rw = id_reg_write; occ_mr = id_mem_read;
            end else if (occ_valid && ex_ready) begin
                occ_valid = 1'b0;
            end
        end
        @(negedge clk);
        #3;
        check("rnd_drain_q", XLEN'(exp_q.size()), 0);
        check("rnd_drain_valid", XLEN'(ex_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_issue_reg.md
# ex_issue_reg

ID/EX pipeline stage register that sits directly upstream of the 32-bit ALU. It captures decoded operands and control from decode and selects register-or-immediate operand B. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and stalls decode with a bubble on load-use. It drives the ALU's `dataA`, `dataB` and `alu_op` inputs under a valid/ready handshake.

## Interface
- `XLEN`, 32, data width
- `REGW`, 5, register index width
- `clk` input 1: rising-edge clock
- `rst_n` input 1: asynchronous active-low reset
- `id_valid` input 1: decode holds an instruction
- `id_ready` output 1: stage accepts this cycle
- `id_rs1`, `id_rs2` input REGW: source indices
- `id_rs1_data`, `id_rs2_data` input XLEN: register-file read data
- `id_imm` input XLEN: sign-extended immediate
- `id_use_imm` input 1: operand B = immediate
- `id_alu_op` input 3: ALU op code
- `id_rd` input REGW: destination index
- `id_reg_write` input 1: instruction writes rd
- `id_mem_read` input 1: instruction is a load
- `flush` input 1: kill stage contents (branch redirect)
- `ex_ready` input 1: downstream consumes
- `ex_valid` output 1: stage holds a live instruction
- `alu_a`, `alu_b` output XLEN: ALU operands
- `alu_op` output 3: registered op code
- `ex_rd` output REGW: registered destination
- `ex_reg_write` output 1: registered write enable
- `ex_mem_read` output 1: registered load flag
- `exm_rd` input REGW, `exm_reg_write` input 1, `exm_result` input XLEN: EX/MEM producer
- `wb_rd` input REGW, `wb_reg_write` input 1, `wb_result` input XLEN: MEM/WB producer

## Operation
- Registered fields: valid, rs1/rs2 index, rs1/rs2 data, imm, use_imm, alu_op, rd, reg_write, mem_read.
- Transfer in: `id_valid && id_ready` at a rising edge loads all fields and sets valid.
- Transfer out: `ex_valid && ex_ready`. If there is no simultaneous transfer in, valid clears (bubble).
- `id_ready = (!ex_valid || ex_ready) && !hazard`.
- Load-use hazard: `ex_valid && ex_mem_read && ex_rd != 0` and `ex_rd` equals `id_rs1` or `id_rs2`. Comparison is unconditional, not gated by `id_use_imm`.
- Forwarding, per source, combinational on the register outputs:
  - An EX/MEM match with `exm_reg_write` and rd ≠ 0 wins.
  - Otherwise a MEM/WB match with `wb_reg_write` and rd ≠ 0 is used.
  - Otherwise the registered data is used.
  - x0 is never forwarded.
- `alu_a` = forwarded rs1.
- `alu_b` = imm when use_imm, otherwise forwarded rs2.
- Operand refresh: while `ex_valid && !ex_ready`, the rs1/rs2 data registers reload with their forwarded values every cycle, so producers retiring during the stall are not lost.
- `flush` clears valid at the next edge and blocks capture that cycle. It wins over the transfer in, the hold and the hazard.
- The `alu_op` encoding is fixed: 000 ADD, 001 SUB, 010 OR, 011 XOR, 100 AND, 101 SRA, 110 SRL, 111 SLL.

## Timing
- Reset (asynchronous, `rst_n` low): `ex_valid`=0 and every registered field 0. As a result `alu_a`=0 when the producers are idle, `alu_b`=0, `alu_op`=000, `ex_rd`=0, `ex_reg_write`=0, `ex_mem_read`=0. `id_ready`=1 after reset.
- Reset mid-operation discards the held instruction immediately, without waiting for a clock edge.
- Latency: 1 cycle from the decode handshake to `ex_valid`.
- Throughput: 1 instruction per cycle with no hazard.
- A load-use hazard costs exactly 1 bubble cycle.
- `id_ready`, `alu_a` and `alu_b` are combinational.
- Simultaneous transfer in and out: the new instruction replaces the old one and `ex_valid` stays 1.

## Configuration
- `EX_FORWARD_EN` defined: forwarding and operand refresh exactly as above.
- `EX_FORWARD_EN` undefined:
  - No forwarding; `alu_a`/`alu_b` come straight from the registers.
  - The hazard extends to any rs1/rs2 (nonzero) match against a writing `ex_rd`, `exm_rd` or `wb_rd`.
  - Decode stalls until the match clears.
  - Ports are unchanged.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum for the eight op codes.
  - `XLEN` and `REGW` constants.
  - `fwd_sel_t` (NONE, EXM, WB).
- One sub-module, `fwd_mux`, instantiated twice (rs1, rs2). It takes the index, registered data and both producers, and returns forwarded data plus the select.

## Test plan
- Reset mid-stream with `ex_valid`=1 → all outputs 0 and `id_ready`=1 while `rst_n` is low.
- `ADDI` with rs1=x1 (data 5), imm=7, `ex_ready`=1 → next cycle `alu_a`=5, `alu_b`=7, `alu_op`=000, `ex_valid`=1.
- Held instruction (rs1=x3, registered 0) with `exm_rd`=3, `exm_reg_write`=1, `exm_result`=0xAA and `wb_rd`=3, `wb_result`=0xBB → `alu_a`=0xAA. With `exm_rd`=0 instead → 0xBB. `ex_ready`=0 for 2 cycles as the producers retire → `alu_a` stays 0xAA.
- Load into x4 in the stage, then decode presents rs2=x4 → `id_ready`=0 for 1 cycle, one bubble (`ex_valid`=0), then capture.
- `flush`=1 coincident with `id_valid`=1 and `ex_valid`=1 → next cycle `ex_valid`=0, and the decoded instruction is not captured.
- With `EX_FORWARD_EN` undefined: rs1=x2 while `exm_rd`=2 is writing → `id_ready`=0 until `exm_reg_write` and `wb_reg_write` no longer match.
